// File: rtl/clock_set_controller.sv
// clock_set_controller: debounced front-panel mode FSM driving clock enable, adjust pulses and blink masks.
// Defining CLKCTRL_AUTOREPEAT_EN adds auto-repeat of a held inc/inc10 button in the SET states.
module clock_set_controller #(
    parameter int DEBOUNCE_CYC  = 20,
    parameter int TIMEOUT_CYC   = 1000,
    parameter int BLINK_HALF    = 25,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_inc10,
    output logic       clk_en,
    output logic       adjust_hour,
    output logic       adjust_minute,
    output logic       adjust_minute_10,
    output logic [1:0] mode,
    output logic       blink_hour,
    output logic       blink_min
);
    typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10} state_t;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("REPEAT_PERIOD must lie in 1..REPEAT_DELAY");
    end
    state_t state_q, state_d;
    logic [2:0] sync1_q, sync2_q, deb_q, deb_d, deb_dly_q, press;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];
    logic [TW-1:0] idle_q, idle_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic phase_q, phase_d, clk_en_q, clk_en_d;
    logic adj_hour_q, adj_hour_d, adj_min_q, adj_min_d, adj_min10_q, adj_min10_d;
    logic fire, fire_m, fire10, timeout, enter;
    // bit 0 = mode, bit 1 = inc, bit 2 = inc10
    assign press = deb_q & ~deb_dly_q;
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) deb_d[i] = sync2_q[i];
                else db_cnt_d[i] = db_cnt_q[i] + DW'(1);
            end
        end
    end
`ifdef CLKCTRL_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic held, act_press;
    assign held = (state_q == SET_HOUR) ? deb_q[1] : (state_q == SET_MIN) ? |deb_q[2:1] : 1'b0;
    assign act_press = !press[0] && ((state_q == SET_HOUR) ? press[1] : (state_q == SET_MIN) && |press[2:1]);
    assign fire = held && rep_q == RW'(REPEAT_DELAY);
    // rep_q counts cycles since the initiating press; zero means no repeat pending
    always_comb begin
        rep_d = (state_d != state_q || !held) ? '0 :
                act_press ? RW'(1) :
                fire ? RW'(REPEAT_DELAY - REPEAT_PERIOD + 1) :
                (rep_q != '0) ? rep_q + RW'(1) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_q <= '0;
        else rep_q <= rep_d;
    end
`else
    assign fire = 1'b0;
`endif
    assign fire10 = fire && state_q == SET_MIN && deb_q[2];
    assign fire_m = fire && state_q == SET_MIN && !deb_q[2];
    always_comb begin
        adj_hour_d  = state_q == SET_HOUR && !press[0] && (press[1] || fire);
        adj_min10_d = state_q == SET_MIN && !press[0] && (press[2] || fire10);
        adj_min_d   = state_q == SET_MIN && !press[0] && !adj_min10_d && (press[1] || fire_m);
        timeout     = state_q != RUN && idle_q == TW'(TIMEOUT_CYC - 1) && !(|press) && !fire;
        state_d     = press[0] ? ((state_q == RUN) ? SET_HOUR : (state_q == SET_HOUR) ? SET_MIN : RUN) :
                      timeout ? RUN : state_q;
        enter       = state_d != state_q && state_d != RUN;
        idle_d      = (state_d == RUN || enter || |press || fire) ? '0 : idle_q + TW'(1);
        blink_cnt_d = (enter || blink_cnt_q == BW'(BLINK_HALF - 1)) ? '0 : blink_cnt_q + BW'(1);
        phase_d     = enter ? 1'b1 : (blink_cnt_q == BW'(BLINK_HALF - 1)) ? !phase_q : phase_q;
        clk_en_d    = state_d == RUN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_dly_q   <= '0;
            db_cnt_q    <= '{default: '0};
            state_q     <= RUN;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            clk_en_q    <= 1'b0;
            adj_hour_q  <= 1'b0;
            adj_min_q   <= 1'b0;
            adj_min10_q <= 1'b0;
        end else begin
            sync1_q     <= {btn_inc10, btn_inc, btn_mode};
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_dly_q   <= deb_q;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            clk_en_q    <= clk_en_d;
            adj_hour_q  <= adj_hour_d;
            adj_min_q   <= adj_min_d;
            adj_min10_q <= adj_min10_d;
        end
    end
    assign clk_en           = clk_en_q;
    assign adjust_hour      = adj_hour_q;
    assign adjust_minute    = adj_min_q;
    assign adjust_minute_10 = adj_min10_q;
    assign mode             = state_q;
    assign blink_hour       = phase_q && state_q == SET_HOUR;
    assign blink_min        = phase_q && state_q == SET_MIN;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: random and directed front-panel stimulus against a cycle-level behavioural model.
module tb_clock_set_controller;
    localparam int DB = 4, TO = 64, BH = 8, RD = 16, RP = 4;
`ifdef CLKCTRL_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0, btn_inc10 = 1'b0;
    logic clk_en, adjust_hour, adjust_minute, adjust_minute_10, blink_hour, blink_min;
    logic [1:0] mode;
    int checks = 0, failures = 0, cyc = 0;
    int hour_cnt = 0, min_cnt = 0, min10_cnt = 0, last_pulse_cyc = 0;
    typedef struct {int cyc; int kind;} pulse_t;
    pulse_t exp_q[$];
    int m_md, m_idle, m_bcnt, m_age;
    bit m_phase, m_ce;
    bit s1[3], s2[3], deb[3], prev[3];
    int streak[3];

    clock_set_controller #(
        .DEBOUNCE_CYC(DB), .TIMEOUT_CYC(TO), .BLINK_HALF(BH),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_inc10(btn_inc10),
        .clk_en(clk_en), .adjust_hour(adjust_hour), .adjust_minute(adjust_minute),
        .adjust_minute_10(adjust_minute_10), .mode(mode), .blink_hour(blink_hour), .blink_min(blink_min)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_md = 0; m_idle = 0; m_bcnt = 0; m_age = -1; m_phase = 0; m_ce = 0;
        for (int b = 0; b < 3; b++) begin
            s1[b] = 0; s2[b] = 0; deb[b] = 0; prev[b] = 0; streak[b] = 0;
        end
        exp_q.delete();
    endtask

    // Pulse kinds: 1 = hour, 2 = minute, 3 = minute+10; mode 0/1/2 = RUN/SET_HOUR/SET_MIN
    task automatic model_step();
        bit pm, pi, p10, any, ha, fire, act;
        bit raw[3];
        int k, nmd;
        raw = '{btn_mode, btn_inc, btn_inc10};
        pm = deb[0] && !prev[0];
        pi = deb[1] && !prev[1];
        p10 = deb[2] && !prev[2];
        any = pm || pi || p10;
        ha = (m_md == 1 && deb[1]) || (m_md == 2 && (deb[1] || deb[2]));
        fire = AR && ha && m_age >= RD && (m_age - RD) % RP == 0;
        k = 0;
        if (m_md == 1 && !pm && (pi || fire)) k = 1;
        if (m_md == 2 && !pm) begin
            if (p10 || (fire && deb[2])) k = 3;
            else if (pi || fire) k = 2;
        end
        nmd = pm ? (m_md + 1) % 3 : (m_md != 0 && !any && !fire && m_idle == TO - 1) ? 0 : m_md;
        if (nmd != m_md && nmd != 0) begin
            m_bcnt = 0; m_phase = 1;
        end else begin
            m_bcnt++;
            if (m_bcnt == BH) begin m_bcnt = 0; m_phase = !m_phase; end
        end
        m_idle = (nmd == 0 || nmd != m_md || any || fire) ? 0 : m_idle + 1;
        act = !pm && ((m_md == 1 && pi) || (m_md == 2 && (pi || p10)));
        if (nmd != m_md || !ha) m_age = -1;
        else if (act) m_age = 0;
        else if (m_age >= 0) m_age++;
        m_md = nmd;
        m_ce = (nmd == 0);
        if (k != 0) exp_q.push_back('{cyc + 1, k});
        for (int b = 0; b < 3; b++) begin
            prev[b] = deb[b];
            if (s2[b] != deb[b]) begin
                streak[b]++;
                if (streak[b] == DB) begin deb[b] = s2[b]; streak[b] = 0; end
            end else streak[b] = 0;
        end
        s2 = s1;
        s1 = raw;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin : monitor
        int k;
        forever begin
            @(negedge clk);
            check("mode", mode, m_md);
            check("clk_en", clk_en, m_ce);
            check("blink_hour", blink_hour, m_phase && m_md == 1);
            check("blink_min", blink_min, m_phase && m_md == 2);
            check("adjust_onehot", (adjust_hour + adjust_minute + adjust_minute_10) <= 1, 1);
            k = adjust_minute_10 ? 3 : adjust_minute ? 2 : adjust_hour ? 1 : 0;
            if (adjust_hour) begin hour_cnt++; last_pulse_cyc = cyc; end
            if (adjust_minute) min_cnt++;
            if (adjust_minute_10) min10_cnt++;
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("pulse_kind", k, exp_q[0].kind);
                void'(exp_q.pop_front());
            end else if (k != 0) check("unexpected_pulse", k, 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit m, input bit i, input bit t, input int hold);
        btn_mode = m; btn_inc = i; btn_inc10 = t;
        tick(hold);
        btn_mode = 0; btn_inc = 0; btn_inc10 = 0;
        tick(12);
    endtask

    initial begin : stim
        int h0, m0, t0, n0;
        tick(5);
        check("reset_mode", mode, 0);
        check("reset_clk_en", clk_en, 0);
        rst = 0;
        tick(1);
        check("clk_en_after_release", clk_en, 1);
        tick(200);
        check("idle_no_pulses", hour_cnt + min_cnt + min10_cnt, 0);
        press(1, 0, 0, 8);
        check("walk_set_hour", mode, 1);
        check("walk_set_hour_clk_en", clk_en, 0);
        h0 = hour_cnt;
        btn_inc = 1; tick(3); btn_inc = 0; tick(12);
        check("glitch_no_pulse", hour_cnt - h0, 0);
        h0 = hour_cnt; t0 = cyc;
        press(0, 1, 0, 10);
        check("clean_press_one_pulse", hour_cnt - h0, 1);
        check("press_latency", (last_pulse_cyc - t0 >= 6) && (last_pulse_cyc - t0 <= 8), 1);
        press(1, 0, 0, 8);
        check("walk_set_min", mode, 2);
        check("walk_set_min_clk_en", clk_en, 0);
        m0 = min_cnt; n0 = min10_cnt;
        press(0, 1, 0, 8);
        check("inc_minute", min_cnt - m0, 1);
        press(0, 0, 1, 8);
        check("inc_minute10", min10_cnt - n0, 1);
        press(0, 1, 1, 8);
        check("both_minute10", min10_cnt - n0, 2);
        check("both_no_minute", min_cnt - m0, 1);
        press(1, 0, 0, 8);
        check("walk_run", mode, 0);
        check("walk_run_clk_en", clk_en, 1);
        t0 = hour_cnt + min_cnt + min10_cnt;
        press(0, 1, 0, 8);
        check("run_inc_ignored", hour_cnt + min_cnt + min10_cnt - t0, 0);
        press(1, 0, 0, 8);
        tick(70);
        check("timeout_mode", mode, 0);
        check("timeout_clk_en", clk_en, 1);
        press(1, 0, 0, 8);
        h0 = hour_cnt;
        press(1, 1, 0, 8);
        check("mode_beats_inc", mode, 2);
        check("mode_beats_inc_pulse", hour_cnt - h0, 0);
        #2 rst = 1;
        #1;
        check("async_reset_mode", mode, 0);
        check("async_reset_clk_en", clk_en, 0);
        check("async_reset_blink", blink_min, 0);
        tick(3);
        rst = 0;
        tick(2);
        press(1, 0, 0, 8);
        h0 = hour_cnt;
        btn_inc = 1; tick(40); btn_inc = 0; tick(12);
        check("repeat_pulse_count", hour_cnt - h0, AR ? 7 : 1);
        repeat (150) begin
            btn_mode = ($urandom_range(0, 7) == 0);
            btn_inc = ($urandom_range(0, 2) == 0);
            btn_inc10 = ($urandom_range(0, 2) == 0);
            tick($urandom_range(1, 30));
            if ($urandom_range(0, 50) == 0) begin
                #2 rst = 1;
                tick(2);
                rst = 0;
            end
        end
        btn_mode = 0; btn_inc = 0; btn_inc10 = 0;
        tick(30);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Front-panel controller that sequences time-setting of the digital clock counter.
- Debounces three raw buttons and runs a mode state machine: RUN, then SET_HOUR, then SET_MIN.
- Drives the clock's enable and its adjust_hour / adjust_minute / adjust_minute_10 inputs as single-cycle pulses.
- Provides blink masks for the hour and minute display digits.

Parameters:
- DEBOUNCE_CYC, 20: consecutive stable cycles before a debounced level changes.
- TIMEOUT_CYC, 1000: idle cycles in a SET state before automatic return to RUN.
- BLINK_HALF, 25: cycles per blink half-period.
- REPEAT_DELAY, 50: hold cycles before auto-repeat starts (optional feature only).
- REPEAT_PERIOD, 10: cycles between auto-repeat pulses (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- btn_mode  in  1  raw mode button, asynchronous, active-high
- btn_inc  in  1  raw increment button
- btn_inc10  in  1  raw minute+10 button
- clk_en  out  1  run enable to the clock counter
- adjust_hour  out  1  one-cycle hour increment pulse
- adjust_minute  out  1  one-cycle minute increment pulse
- adjust_minute_10  out  1  one-cycle minute+10 pulse
- mode  out  2  00=RUN, 01=SET_HOUR, 10=SET_MIN; 11 is never driven
- blink_hour  out  1  1 = blank the hour digits this cycle
- blink_min  out  1  1 = blank the minute digits this cycle

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high.
  - On reset assertion, all outputs go to 0 immediately: mode=00, clk_en=0, all adjust_* pulses 0, blinks 0.
  - All counters clear and the debounced levels clear.
  - clk_en rises on the first clk edge after rst deasserts.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer.
  - A per-button counter tracks the synchronized value. The debounced level takes that value only after it has differed from the debounced level for DEBOUNCE_CYC consecutive cycles. Any glitch restarts the count.
  - A press event is a 0-to-1 transition of the debounced level, lasting 1 cycle.
- FSM (registered):
  - RUN: a mode press goes to SET_HOUR. inc and inc10 presses are ignored.
  - SET_HOUR: a mode press goes to SET_MIN. An inc press generates an adjust_hour pulse. inc10 is ignored.
  - SET_MIN: a mode press goes to RUN. An inc press generates an adjust_minute pulse. An inc10 press generates an adjust_minute_10 pulse.
  - clk_en = 1 only in RUN; the clock is frozen while setting.
- Pulse timing:
  - A press event in cycle N gives the corresponding adjust pulse high in cycle N+1 only.
  - A mode press in cycle N makes the new mode visible in cycle N+1.
- Priority on simultaneous events:
  - Mode and inc/inc10 press in the same cycle: the mode transition wins and the increment is dropped.
  - inc and inc10 press in the same cycle in SET_MIN: adjust_minute_10 only.
  - At most one adjust_* output is high in any cycle.
- Timeout:
  - An idle counter runs in the SET states. It clears on any press event and on entry to a SET state.
  - When it reaches TIMEOUT_CYC-1, the next cycle is RUN.
  - The counter is held at 0 in RUN.
- Blink:
  - The phase counter wraps every BLINK_HALF cycles and toggles a phase bit.
  - On entry to a SET state the counter clears and phase=1 (blanked first).
  - blink_hour = phase && mode==SET_HOUR; blink_min = phase && mode==SET_MIN. Both are 0 in RUN.
- Wrap-around of hour and minute values is owned by the clock counter, not by this block.

Optional Feature:
- Macro: CLKCTRL_AUTOREPEAT_EN.
- Defined:
  - While the debounced inc or inc10 is held in a SET state in which that button is active, auto-repeat runs.
  - REPEAT_DELAY cycles after the initial pulse, a further pulse of the same type fires, then one every REPEAT_PERIOD cycles.
  - Repeat stops on release, on a mode change, or on timeout.
  - Each repeat pulse clears the timeout counter.
  - If both inc and inc10 are held, only inc10 repeats.
- Undefined: exactly one pulse per press event; the repeat counters are absent.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, TIMEOUT_CYC=64, BLINK_HALF=8, REPEAT_DELAY=16, REPEAT_PERIOD=4.
- Reset/idle: rst high for 5 cycles, then low -> all outputs 0 during reset; clk_en=1 from the first edge after release; mode=00; no pulses over 200 cycles with buttons idle.
- Debounce: btn_inc glitch of 3 cycles in SET_HOUR -> no pulse. Clean press held for 10 cycles -> exactly one adjust_hour pulse, 1 cycle wide, high 4+2+1 cycles after the raw edge (±1).
- Mode walk: three mode presses -> mode 01, 10, 00 in order; clk_en 0, 0, 1. blink_hour toggles every 8 cycles only while mode=01.
- SET_MIN increments: inc press -> one adjust_minute pulse. inc10 press -> one adjust_minute_10 pulse. Both pressed in the same cycle -> adjust_minute_10 only. inc press in RUN -> no pulse.
- Timeout and priority:
  - In SET_HOUR with no press for 64 cycles -> mode=00 and clk_en=1.
  - Mode and inc pressed in the same cycle in SET_HOUR -> mode=10 with no adjust_hour pulse.
  - rst pulse mid-SET_MIN -> mode=00 immediately.
- Auto-repeat, with CLKCTRL_AUTOREPEAT_EN defined:
  - Hold inc for 40 debounced cycles in SET_HOUR -> adjust_hour pulses at offsets 1, 17, 21, 25, 29, 33, 37 (7 pulses).
  - Same stimulus without the macro -> 1 pulse.
